mvu_pe_acc: RTL



---
 rtl/mvu_pe_acc.sv | 109 ++++++++++
 1 files changed

// File: rtl/mvu_pe_acc.sv
// -----------------------------------------------------------------------------
// mvu_pe_acc
//   Accumulation back end of an MVU processing element. Each beat carries SIMD
//   signed lane products. The lanes are reduced into one registered sum
//   (stage 1). That sum is then accumulated across SF synapse folds (stage 2).
//   One TA-bit result per output neuron leaves on a valid/ready stream.
//   out_v/out_rdy is the only backpressure point. A stalled output freezes
//   the whole pipeline through a single global enable.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   in_v     in   product vector valid
//   in_rdy   out  beat can be accepted (combinational from out_v/out_rdy)
//   in_prod  in   packed lane products, lane i = in_prod[i*TO +: TO]
//   out_v    out  result valid
//   out_rdy  in   downstream accepts result
//   out_d    out  accumulated result, wraps modulo 2^TA
// -----------------------------------------------------------------------------
module mvu_pe_acc #(
  parameter int SIMD = 2,
  parameter int TO   = 16,
  parameter int TA   = 32,
  parameter int SF   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_v,
  output logic               in_rdy,
  input  logic [SIMD*TO-1:0] in_prod,
  output logic               out_v,
  input  logic               out_rdy,
  output logic [TA-1:0]      out_d
);

  localparam int CW = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

  logic          en;
  logic          s1_v;
  logic [TA-1:0] s1_sum;
  logic [TA-1:0] lane_sum;
  logic [TA-1:0] acc;
  logic [TA-1:0] base;
  logic [TA-1:0] fold_sum;
  logic [CW-1:0] cnt;
  logic          fold_last;

  // The pipeline only stalls while a finished result waits on downstream.
  assign en     = !(out_v && !out_rdy);
  assign in_rdy = en;

  // Lane reduction. Each lane is sign-extended to TA bits before the add,
  // so negative products wrap correctly in the accumulator width.
  // NOTE: give every always_comb variable a default before any conditional
  // or loop update. Otherwise a missed path infers a latch.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < SIMD; i++) begin
      lane_sum = lane_sum + TA'($signed(in_prod[i*TO +: TO]));
    end
  end

  // Fold 0 starts from zero instead of clearing acc on a separate edge.
  // The final fold therefore never needs to write acc back.
  assign base      = (cnt == '0) ? '0 : acc;
  assign fold_sum  = base + s1_sum;
  assign fold_last = (cnt == CNT_LAST);

  // Stage 1: registered lane sum. Bubbles clear s1_v and leave stage 2 alone.
  // NOTE: state registers use non-blocking assignments. All flops then sample
  // pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
    end else if (en) begin
      s1_v   <= in_v;
      s1_sum <= lane_sum;
    end
  end

  // Stage 2: fold accumulation and output register.
  // A result may transfer on the same edge a new one loads. The load wins,
  // so out_v is dropped only when nothing new is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      out_v <= 1'b0;
      out_d <= '0;
    end else if (en) begin
      if (s1_v && fold_last) begin
        out_d <= fold_sum;
        out_v <= 1'b1;
        cnt   <= '0;
      end else begin
        if (s1_v) begin
          acc <= fold_sum;
          cnt <= cnt + CW'(1);
        end
        if (out_v && out_rdy) begin
          out_v <= 1'b0;
        end
      end
    end
  end

endmodule
